// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller with multiply-divide unit busy sequencer.
// Optional stall statistics counter enabled by macro PIPE_CTRL_STALL_STAT_EN.
module pipe_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        Req,
   input  logic [4:0]  D_rs_addr,
   input  logic [4:0]  D_rt_addr,
   input  logic        D_rs_used,
   input  logic        D_rt_used,
   input  logic [1:0]  D_Tuse_rs,
   input  logic [1:0]  D_Tuse_rt,
   input  logic [4:0]  E_A3,
   input  logic [4:0]  M_A3,
   input  logic [1:0]  E_Tnew,
   input  logic [1:0]  M_Tnew,
   input  logic        D_md,
   input  logic        E_md_start,
   input  logic        E_md_div,
   input  logic        D_eret,
   input  logic        E_mtc0_epc,
   input  logic        M_mtc0_epc,
   output logic        stall,
   output logic        F_en,
   output logic        D_en,
   output logic        md_busy,
   output logic [3:0]  md_cnt
`ifdef PIPE_CTRL_STALL_STAT_EN
   ,
   output logic [31:0] stall_cnt
`endif
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   localparam logic [3:0] MULT_CYCLES = 4'd5;
   localparam logic [3:0] DIV_CYCLES  = 4'd10;

   logic [3:0] md_cnt_r;
   logic [3:0] md_cnt_nxt_s;
   logic [0:0] state_s;
   logic       start_ok_s;
   logic       stall_rs_s;
   logic       stall_rt_s;
   logic       stall_md_s;
   logic       stall_eret_s;
   logic       stall_s;
   logic       md_busy_s;

   // Operand hazards, MDU contention and eret/EPC ordering; Req overrides every stall.
   always_comb begin
      stall_rs_s   = D_rs_used && (D_rs_addr != 5'd0) &&
                     (((E_A3 == D_rs_addr) && (E_Tnew > D_Tuse_rs)) ||
                      ((M_A3 == D_rs_addr) && (M_Tnew > D_Tuse_rs)));
      stall_rt_s   = D_rt_used && (D_rt_addr != 5'd0) &&
                     (((E_A3 == D_rt_addr) && (E_Tnew > D_Tuse_rt)) ||
                      ((M_A3 == D_rt_addr) && (M_Tnew > D_Tuse_rt)));
      start_ok_s   = E_md_start && !Req;
      md_busy_s    = start_ok_s || (md_cnt_r != 4'd0);
      stall_md_s   = D_md && md_busy_s;
      stall_eret_s = D_eret && (E_mtc0_epc || M_mtc0_epc);
      stall_s      = (stall_rs_s || stall_rt_s || stall_md_s || stall_eret_s) && !Req;
   end

   assign stall   = stall_s;
   assign F_en    = ~stall_s;
   assign D_en    = ~stall_s;
   assign md_busy = md_busy_s;
   assign md_cnt  = md_cnt_r;

   assign state_s = (md_cnt_r != 4'd0) ? ST_BUSY : ST_IDLE;

   // MDU sequencer next count: starts only from idle, never reloads while busy.
   always_comb begin
      md_cnt_nxt_s = md_cnt_r;
      case (state_s)
         ST_IDLE: begin
            if (start_ok_s) begin
               md_cnt_nxt_s = E_md_div ? DIV_CYCLES : MULT_CYCLES;
            end else begin
               md_cnt_nxt_s = 4'd0;
            end
         end
         ST_BUSY: begin
            md_cnt_nxt_s = md_cnt_r - 4'd1;
         end
         default: begin
            md_cnt_nxt_s = 4'd0;
         end
      endcase
   end

   // MDU remaining-cycle register.
   always_ff @(posedge clk) begin
      if (reset) begin
         md_cnt_r <= 4'd0;
      end else begin
         md_cnt_r <= md_cnt_nxt_s;
      end
   end

`ifdef PIPE_CTRL_STALL_STAT_EN
   logic [31:0] stall_cnt_r;

   // Free-running stall cycle counter, wraps naturally at 32 bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_r <= 32'd0;
      end else if (stall_s) begin
         stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table, directed MDU/reset sequences,
// and randomized traffic against a cycle-indexed reference model.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        Req;
   logic [4:0]  D_rs_addr, D_rt_addr;
   logic        D_rs_used, D_rt_used;
   logic [1:0]  D_Tuse_rs, D_Tuse_rt;
   logic [4:0]  E_A3, M_A3;
   logic [1:0]  E_Tnew, M_Tnew;
   logic        D_md, E_md_start, E_md_div;
   logic        D_eret, E_mtc0_epc, M_mtc0_epc;
   logic        stall, F_en, D_en, md_busy;
   logic [3:0]  md_cnt;
`ifdef PIPE_CTRL_STALL_STAT_EN
   logic [31:0] stall_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   pipe_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .Req        (Req),
      .D_rs_addr  (D_rs_addr),
      .D_rt_addr  (D_rt_addr),
      .D_rs_used  (D_rs_used),
      .D_rt_used  (D_rt_used),
      .D_Tuse_rs  (D_Tuse_rs),
      .D_Tuse_rt  (D_Tuse_rt),
      .E_A3       (E_A3),
      .M_A3       (M_A3),
      .E_Tnew     (E_Tnew),
      .M_Tnew     (M_Tnew),
      .D_md       (D_md),
      .E_md_start (E_md_start),
      .E_md_div   (E_md_div),
      .D_eret     (D_eret),
      .E_mtc0_epc (E_mtc0_epc),
      .M_mtc0_epc (M_mtc0_epc),
      .stall      (stall),
      .F_en       (F_en),
      .D_en       (D_en),
      .md_busy    (md_busy),
      .md_cnt     (md_cnt)
`ifdef PIPE_CTRL_STALL_STAT_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Reference MDU model: the cycle index at which the running operation ends.
   int cyc     = 0;
   int md_done = 0;
   always @(posedge clk) begin
      if (reset) begin
         md_done <= 0;
      end else if (md_done <= cyc && E_md_start && !Req) begin
         md_done <= cyc + 1 + (E_md_div ? 10 : 5);
      end
      cyc <= cyc + 1;
   end

   function automatic int ref_cnt();
      return (md_done > cyc) ? (md_done - cyc) : 0;
   endfunction

   function automatic logic ref_busy();
      return (E_md_start && !Req) || (ref_cnt() != 0);
   endfunction

   function automatic logic ref_stall();
      logic h_rs, h_rt, h_md, h_er;
      h_rs = D_rs_used && D_rs_addr != 5'd0 &&
             ((E_A3 == D_rs_addr && E_Tnew > D_Tuse_rs) || (M_A3 == D_rs_addr && M_Tnew > D_Tuse_rs));
      h_rt = D_rt_used && D_rt_addr != 5'd0 &&
             ((E_A3 == D_rt_addr && E_Tnew > D_Tuse_rt) || (M_A3 == D_rt_addr && M_Tnew > D_Tuse_rt));
      h_md = D_md && ref_busy();
      h_er = D_eret && (E_mtc0_epc || M_mtc0_epc);
      return (h_rs || h_rt || h_md || h_er) && !Req;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      Req = 1'b0; D_rs_addr = 5'd0; D_rt_addr = 5'd0; D_rs_used = 1'b0; D_rt_used = 1'b0;
      D_Tuse_rs = 2'd0; D_Tuse_rt = 2'd0; E_A3 = 5'd0; M_A3 = 5'd0; E_Tnew = 2'd0; M_Tnew = 2'd0;
      D_md = 1'b0; E_md_start = 1'b0; E_md_div = 1'b0; D_eret = 1'b0; E_mtc0_epc = 1'b0; M_mtc0_epc = 1'b0;
   endtask

   typedef struct {
      logic [4:0] rs, rt;
      logic       rs_used, rt_used;
      logic [1:0] tuse_rs, tuse_rt;
      logic [4:0] e_a3, m_a3;
      logic [1:0] e_tnew, m_tnew;
      logic       eret, e_epc, m_epc, req;
      logic       exp_stall;
   } vec_t;

   vec_t vecs[10];

   initial begin
      //          rs     rt     rsu   rtu   tus   tut   ea3    ma3    etn   mtn   eret  eepc  mepc  req   exp
      vecs[0] = '{5'd8, 5'd0, 1'b1, 1'b0, 2'd0, 2'd0, 5'd8, 5'd0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[1] = '{5'd0, 5'd0, 1'b1, 1'b0, 2'd0, 2'd0, 5'd8, 5'd0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{5'd0, 5'd5, 1'b0, 1'b1, 2'd0, 2'd1, 5'd0, 5'd5, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{5'd0, 5'd5, 1'b0, 1'b1, 2'd0, 2'd1, 5'd0, 5'd5, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{5'd8, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd8, 5'd0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd0, 5'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[6] = '{5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd0, 5'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[7] = '{5'd8, 5'd0, 1'b1, 1'b0, 2'd0, 2'd0, 5'd8, 5'd0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[8] = '{5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd0, 5'd0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[9] = '{5'd3, 5'd0, 1'b1, 1'b0, 2'd2, 2'd0, 5'd3, 5'd3, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

      clear_inputs();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("reset_md_cnt", {28'd0, md_cnt}, 32'd0);
      check("reset_md_busy", {31'd0, md_busy}, 32'd0);
      check("reset_stall", {31'd0, stall}, 32'd0);
      check("reset_F_en", {31'd0, F_en}, 32'd1);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         clear_inputs();
         D_rs_addr = vecs[i].rs; D_rt_addr = vecs[i].rt;
         D_rs_used = vecs[i].rs_used; D_rt_used = vecs[i].rt_used;
         D_Tuse_rs = vecs[i].tuse_rs; D_Tuse_rt = vecs[i].tuse_rt;
         E_A3 = vecs[i].e_a3; M_A3 = vecs[i].m_a3;
         E_Tnew = vecs[i].e_tnew; M_Tnew = vecs[i].m_tnew;
         D_eret = vecs[i].eret; E_mtc0_epc = vecs[i].e_epc; M_mtc0_epc = vecs[i].m_epc;
         Req = vecs[i].req;
         #1;
         check($sformatf("vec%0d_stall", i), {31'd0, stall}, {31'd0, vecs[i].exp_stall});
         check($sformatf("vec%0d_F_en", i), {31'd0, F_en}, {31'd0, ~vecs[i].exp_stall});
         check($sformatf("vec%0d_D_en", i), {31'd0, D_en}, {31'd0, ~vecs[i].exp_stall});
      end

      // Divide with dependent MDU instruction held in D.
      @(negedge clk);
      clear_inputs();
      D_md = 1'b1; E_md_start = 1'b1; E_md_div = 1'b1;
      #1;
      check("div_N_stall", {31'd0, stall}, 32'd1);
      check("div_N_cnt", {28'd0, md_cnt}, 32'd0);
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         E_md_start = 1'b0; E_md_div = 1'b0;
         #1;
         check($sformatf("div_N+%0d_cnt", k), {28'd0, md_cnt}, 32'(11 - k));
         check($sformatf("div_N+%0d_stall", k), {31'd0, stall}, (k <= 10) ? 32'd1 : 32'd0);
      end

      // Start flushed by Req in the same cycle.
      @(negedge clk);
      clear_inputs();
      D_md = 1'b1; E_md_start = 1'b1; Req = 1'b1;
      #1;
      check("flush_start_stall", {31'd0, stall}, 32'd0);
      check("flush_start_busy", {31'd0, md_busy}, 32'd0);
      @(negedge clk);
      clear_inputs();
      #1;
      check("flush_start_cnt", {28'd0, md_cnt}, 32'd0);

      // Mult, a start ignored while busy, then reset at md_cnt==3.
      @(negedge clk);
      E_md_start = 1'b1;
      #1;
      check("mult_N_busy", {31'd0, md_busy}, 32'd1);
      @(negedge clk);
      E_md_div = 1'b1;
      #1;
      check("mult_N+1_cnt", {28'd0, md_cnt}, 32'd5);
      @(negedge clk);
      E_md_start = 1'b0; E_md_div = 1'b0;
      #1;
      check("mult_N+2_cnt", {28'd0, md_cnt}, 32'd4);
      @(negedge clk);
      #1;
      check("mult_N+3_cnt", {28'd0, md_cnt}, 32'd3);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("mid_reset_cnt", {28'd0, md_cnt}, 32'd0);
      check("mid_reset_busy", {31'd0, md_busy}, 32'd0);

      // Randomized traffic against the reference model.
      for (int r = 0; r < 600; r++) begin
         @(negedge clk);
         reset      = ($urandom_range(0, 39) == 0);
         Req        = ($urandom_range(0, 7) == 0);
         D_rs_addr  = 5'($urandom_range(0, 3));
         D_rt_addr  = 5'($urandom_range(0, 3));
         D_rs_used  = 1'($urandom);
         D_rt_used  = 1'($urandom);
         D_Tuse_rs  = 2'($urandom);
         D_Tuse_rt  = 2'($urandom);
         E_A3       = 5'($urandom_range(0, 3));
         M_A3       = 5'($urandom_range(0, 3));
         E_Tnew     = 2'($urandom);
         M_Tnew     = 2'($urandom);
         D_md       = 1'($urandom);
         E_md_start = ($urandom_range(0, 5) == 0);
         E_md_div   = 1'($urandom);
         D_eret     = ($urandom_range(0, 3) == 0);
         E_mtc0_epc = ($urandom_range(0, 3) == 0);
         M_mtc0_epc = ($urandom_range(0, 3) == 0);
         #1;
         check("rnd_md_cnt", {28'd0, md_cnt}, 32'(ref_cnt()));
         check("rnd_md_busy", {31'd0, md_busy}, {31'd0, ref_busy()});
         check("rnd_stall", {31'd0, stall}, {31'd0, ref_stall()});
         check("rnd_F_en", {31'd0, F_en}, {31'd0, ~ref_stall()});
         check("rnd_D_en", {31'd0, D_en}, {31'd0, ~ref_stall()});
      end

`ifdef PIPE_CTRL_STALL_STAT_EN
      @(negedge clk);
      clear_inputs();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      D_eret = 1'b1; M_mtc0_epc = 1'b1;
      repeat (7) @(negedge clk);
      clear_inputs();
      #1;
      check("stall_cnt_7", stall_cnt, 32'd7);
      force dut.stall_cnt_r = 32'hFFFF_FFFF;
      #1;
      release dut.stall_cnt_r;
      D_eret = 1'b1; M_mtc0_epc = 1'b1;
      @(negedge clk);
      clear_inputs();
      #1;
      check("stall_cnt_wrap", stall_cnt, 32'd0);
`endif

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, system clock; reset in 1, synchronous active-high reset.
REQ-002 SHALL have ports: Req in 1, exception/interrupt flush request; D_rs_addr, D_rt_addr in 5 each, D-stage source registers; D_rs_used, D_rt_used in 1 each, source actually read.
REQ-003 SHALL have ports: D_Tuse_rs, D_Tuse_rt in 2 each, cycles until D instr needs the operand; E_A3, M_A3 in 5 each, destination registers in E/M; E_Tnew, M_Tnew in 2 each, cycles until the result is ready.
REQ-004 SHALL have ports: D_md in 1, D instr is a mult/div/mfhi/mflo/mthi/mtlo; E_md_start in 1, E instr starts mult/multu/div/divu; E_md_div in 1, the started op is a divide.
REQ-005 SHALL have ports: D_eret in 1; E_mtc0_epc, M_mtc0_epc in 1 each, mtc0 targeting EPC in E/M.
REQ-006 SHALL have outputs: stall 1; F_en 1; D_en 1; md_busy 1; md_cnt 4, remaining MDU cycles.

Function
REQ-007 SHALL compute stall_rs = D_rs_used & D_rs_addr!=0 & ((E_A3==D_rs_addr & E_Tnew>D_Tuse_rs) | (M_A3==D_rs_addr & M_Tnew>D_Tuse_rs)); stall_rt is identical with the rt inputs.
REQ-008 SHALL compute stall_md = D_md & md_busy.
REQ-009 SHALL compute stall_eret = D_eret & (E_mtc0_epc | M_mtc0_epc).
REQ-010 SHALL drive stall = (stall_rs | stall_rt | stall_md | stall_eret) & ~Req; Req always wins.
REQ-011 SHALL drive F_en = D_en = ~stall; all of stall, F_en and D_en are combinational, zero latency.
REQ-012 SHALL implement the MDU sequencer with states IDLE (md_cnt==0) and BUSY (md_cnt!=0).
REQ-013 SHALL, in IDLE, when E_md_start & ~Req, load md_cnt with 10 if E_md_div else 5 at the next edge.
REQ-014 SHALL, in BUSY, decrement md_cnt by 1 each cycle and return to IDLE when md_cnt reaches 0; Req does not abort a running operation.
REQ-015 SHALL ignore E_md_start while BUSY; no reload, no wrap.
REQ-016 SHALL ignore E_md_start when Req is asserted in the same cycle; the flushed instruction never starts.
REQ-017 SHALL drive md_busy = (E_md_start & ~Req) | (md_cnt!=0), combinationally.
REQ-018 SHALL take a 5-cycle mult: start at cycle N gives md_cnt = 5,4,3,2,1 over N+1..N+5 and 0 at N+6; md_busy is high over N..N+5.

Reset
REQ-019 SHALL, when reset is high at a clk edge, set md_cnt=0 (IDLE) and, if compiled in, stall_cnt=0; reset has priority over start and decrement.
REQ-020 SHALL, with reset high, make the outputs follow combinationally from the inputs with md_cnt=0; no output is forced by reset.
REQ-021 SHALL, on reset mid-operation, abandon the MDU count immediately; md_busy falls in the cycle after the reset edge unless E_md_start is high.

Configuration
REQ-022 SHALL, with macro PIPE_CTRL_STALL_STAT_EN defined, add output stall_cnt (out, 32 bits), which increments by 1 at each edge where stall==1 and reset==0 and wraps from 32'hFFFF_FFFF to 0.
REQ-023 SHALL, without PIPE_CTRL_STALL_STAT_EN, have neither the stall_cnt port nor its register; all other behaviour is identical.

Verification
REQ-024 SHALL cover: E_A3=8, E_Tnew=2, D_rs_addr=8, D_Tuse_rs=0, D_rs_used=1 -> stall=1, F_en=0; repeat with D_rs_addr=0 -> stall=0.
REQ-025 SHALL cover: E_md_start=1, E_md_div=1 at cycle N, D_md=1 held -> md_cnt=10 at N+1 and reaches 0 at N+11; stall=1 over N..N+10 and 0 at N+11.
REQ-026 SHALL cover: E_md_start=1 with Req=1 in the same cycle -> md_cnt stays 0 and stall=0.
REQ-027 SHALL cover: D_eret=1 with M_mtc0_epc=1 -> stall=1; then assert Req=1 in the same cycle -> stall=0, F_en=1.
REQ-028 SHALL cover: a mult running with md_cnt=3, then reset high for one edge -> md_cnt=0 and md_busy=0 next cycle.
REQ-029 SHALL cover, with PIPE_CTRL_STALL_STAT_EN defined: 7 stall cycles -> stall_cnt=7; a preset value of 32'hFFFF_FFFF plus one stall cycle -> 0.
